// File: rtl/pdm_pkg.sv
// Shared constants, datapath width helper and warm-up state encoding for the
// PDM decimator.
package pdm_pkg;

  localparam int unsigned LOG2_R_DEF = 8;
  localparam int unsigned OUT_W      = 8;

  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    RUN   = 2'd2
  } warm_state_t;

  function automatic int unsigned cic_width(input int unsigned log2_r);
    return 2 * log2_r + 1;
  endfunction

endpackage

// File: rtl/pdm_cic2.sv
// Second-order CIC decimator core: two integrators, decimation counter and two
// combs. o_tick/o_c2 are registered together on the decimation edge.
module pdm_cic2
  import pdm_pkg::*;
#(
  parameter int unsigned LOG2_R = LOG2_R_DEF,
  parameter int unsigned W      = cic_width(LOG2_R)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_x,
  output logic          o_tick,
  output logic [W-1:0]  o_c2
);

  logic [LOG2_R-1:0] r_cnt;
  logic [W-1:0]      r_i1;
  logic [W-1:0]      r_i2;
  logic [W-1:0]      r_i2_d;
  logic [W-1:0]      r_c1_d;
  logic [W-1:0]      r_c2;
  logic              r_tick;
  logic              w_tick;
  logic [W-1:0]      w_c1;

  assign w_tick = (r_cnt == {LOG2_R{1'b1}});
  assign w_c1   = r_i2 - r_i2_d;

  // Integrators wrap modulo 2^W on purpose; the combs cancel the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_i1   <= '0;
      r_i2   <= '0;
      r_i2_d <= '0;
      r_c1_d <= '0;
      r_c2   <= '0;
      r_tick <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_i1   <= '0;
      r_i2   <= '0;
      r_i2_d <= '0;
      r_c1_d <= '0;
      r_c2   <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + LOG2_R'(1);
      r_i1   <= r_i1 + W'(i_x);
      r_i2   <= r_i2 + r_i1;
      r_tick <= w_tick;
      if (w_tick) begin
        r_i2_d <= r_i2;
        r_c1_d <= w_c1;
        r_c2   <= w_c1 - r_c1_d;
      end
    end
  end

  assign o_tick = r_tick;
  assign o_c2   = r_c2;

endmodule

// File: rtl/pdm_decimator.sv
// PDM-to-8-bit decimator: input synchroniser, CIC2 core, two-tick warm-up,
// scale-and-saturate and registered sample/strobe/overrange outputs.
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter int unsigned LOG2_R  = LOG2_R_DEF,
  parameter bit          SYNC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pdm_in,
  output logic [OUT_W-1:0] data_out,
  output logic             data_valid,
  output logic             overrange
);

  localparam int unsigned W     = cic_width(LOG2_R);
  localparam int unsigned SHIFT = 2 * LOG2_R - 8;

  logic              w_x;
  logic              w_tick;
  logic [W-1:0]      w_c2;
  logic [W-1:0]      w_shifted;
  logic              w_sat;
  logic [OUT_W-1:0]  w_data;
  logic              w_run_tick;
  warm_state_t       r_state;
  warm_state_t       w_state_nxt;
  logic [OUT_W-1:0]  r_data_out;
  logic              r_data_valid;
  logic              r_overrange;

  generate
    if (SYNC_EN) begin : g_sync
      logic r_sync1;
      logic r_sync2;
      // Two-flop synchroniser, cleared with the rest of the datapath.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else if (!en) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= pdm_in;
          r_sync2 <= r_sync1;
        end
      end
      assign w_x = r_sync2;
    end else begin : g_nosync
      assign w_x = pdm_in;
    end
  endgenerate

  pdm_cic2 #(.LOG2_R(LOG2_R), .W(W)) u_cic (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en),
    .i_x    (w_x),
    .o_tick (w_tick),
    .o_c2   (w_c2)
  );

  // Warm-up state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WARM0;
    end else if (!en) begin
      r_state <= WARM0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Warm-up next state: the first two CIC outputs are still settling.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WARM0:   w_state_nxt = w_tick ? WARM1 : WARM0;
      WARM1:   w_state_nxt = w_tick ? RUN : WARM1;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = WARM0;
    endcase
  end

  // Warm-up output decode.
  always_comb begin
    w_run_tick = 1'b0;
    if (r_state == RUN) begin
      w_run_tick = w_tick;
    end else begin
      w_run_tick = 1'b0;
    end
  end

  assign w_shifted = w_c2 >> SHIFT;
  assign w_sat     = |w_shifted[W-1:OUT_W];
  assign w_data    = w_sat ? {OUT_W{1'b1}} : w_shifted[OUT_W-1:0];

  // Output registers; data_out holds between strobes, overrange is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overrange  <= 1'b0;
    end else if (!en) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overrange  <= 1'b0;
    end else begin
      r_data_valid <= w_run_tick;
      if (w_run_tick) begin
        r_data_out <= w_data;
        if (w_sat) begin
          r_overrange <= 1'b1;
        end
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign overrange  = r_overrange;

endmodule
